lcd_access_arbiter: RTL and testbench

Shares the single 4-bit character LCD between several vending-machine requesters (status, error and price message sources, for example). It arbitrates round-robin, locks the winner for a multi-byte message, and splits each byte into two nibble transfers with programmable setup, enable-pulse and hold timing. A post-byte wait covers LCD execution time. It runs after the LCD init sequencer has finished and drives the LCD pins directly.

---
 rtl/lcd_access_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_access_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_access_arbiter.sv
// Round-robin arbiter sharing one 4-bit HD44780-style LCD between requesters.
// Locks the winner for multi-byte messages and emits timed nibble strobes.
module lcd_access_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned PULSE_CYC    = 12,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_CYC     = 2000,
  parameter int unsigned CLR_WAIT_CYC = 80000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lcd_ready,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [8*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [3:0]           lcd_data
);

  localparam int unsigned CLR_W = $clog2(CLR_WAIT_CYC + 1);
  localparam int unsigned CW    = (CLR_W > 17) ? CLR_W : 17;
  localparam int unsigned IW    = $clog2(NUM_REQ);

  localparam logic [CW-1:0] SETUP_M1 = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_M1 = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_M1  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_M1   = CW'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP_HI, PULSE_HI, HOLD_HI, SETUP_LO, PULSE_LO, HOLD_LO, WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              lock_q, lock_d;
  logic [7:0]        byte_q, byte_d;
  logic              rs_q, rs_d;
  logic              last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic              lcd_en_q, lcd_en_d;
  logic [3:0]        lcd_data_q, lcd_data_d;

  logic [7:0]        byte_arr [NUM_REQ];
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW:0]       cand;
  logic [IW-1:0]     owner_inc;
  logic              clr_cmd;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign byte_arr[g] = req_byte[8*g +: 8];
  end

  // Locked: only the owner may win. Unlocked: scan upward from rr_q with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (lock_q) begin
      win_found = req[owner_q];
      win_idx   = owner_q;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, rr_q} + (IW+1)'(i);
        if (cand >= (IW+1)'(NUM_REQ))
          cand = cand - (IW+1)'(NUM_REQ);
        if (!win_found && req[cand[IW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = cand[IW-1:0];
        end
      end
    end
  end

  assign owner_inc = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign clr_cmd   = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02));

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    byte_d     = byte_q;
    rs_d       = rs_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = lcd_en_q;
    lcd_data_d = lcd_data_q;

    case (state_q)
      IDLE: begin
        if (lcd_ready && win_found) begin
          byte_d           = byte_arr[win_idx];
          rs_d             = req_rs[win_idx];
          last_d           = req_last[win_idx];
          owner_d          = win_idx;
          lock_d           = !req_last[win_idx];
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          ack_d[win_idx]   = 1'b1;
          lcd_rs_d         = req_rs[win_idx];
          lcd_data_d       = byte_arr[win_idx][7:4];
          lcd_en_d         = 1'b0;
          cnt_d            = SETUP_M1;
          state_d          = SETUP_HI;
        end
      end
      SETUP_HI: if (cnt_q == '0) begin
        state_d  = PULSE_HI;
        cnt_d    = PULSE_M1;
        lcd_en_d = 1'b1;
      end
      PULSE_HI: if (cnt_q == '0) begin
        state_d  = HOLD_HI;
        cnt_d    = HOLD_M1;
        lcd_en_d = 1'b0;
      end
      HOLD_HI: if (cnt_q == '0) begin
        state_d    = SETUP_LO;
        cnt_d      = SETUP_M1;
        lcd_data_d = byte_q[3:0];
      end
      SETUP_LO: if (cnt_q == '0) begin
        state_d  = PULSE_LO;
        cnt_d    = PULSE_M1;
        lcd_en_d = 1'b1;
      end
      PULSE_LO: if (cnt_q == '0) begin
        state_d  = HOLD_LO;
        cnt_d    = HOLD_M1;
        lcd_en_d = 1'b0;
      end
      HOLD_LO: if (cnt_q == '0) begin
        state_d    = WAIT;
        cnt_d      = clr_cmd ? CLR_M1 : WAIT_M1;
        lcd_data_d = '0;
      end
      WAIT: if (cnt_q == '0) begin
        state_d = IDLE;
        // Release on message end or when the owner abandoned its request.
        if (last_q || !req[owner_q]) begin
          lock_d = 1'b0;
          gnt_d  = '0;
          rr_d   = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      last_q     <= 1'b0;
      gnt_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Directed bench for lcd_access_arbiter with shortened wait times.
module tb_lcd_access_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned WAITC = 20;
  localparam int unsigned CLRC  = 50;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         lcd_ready = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_rs = '0;
  logic [N-1:0] req_last = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0] gnt, ack;
  logic         busy, lcd_rs, lcd_rw, lcd_en;
  logic [3:0]   lcd_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  lcd_access_arbiter #(
    .NUM_REQ(N), .SETUP_CYC(2), .PULSE_CYC(12), .HOLD_CYC(2),
    .WAIT_CYC(WAITC), .CLR_WAIT_CYC(CLRC)
  ) dut (
    .clk(clk), .reset(reset), .lcd_ready(lcd_ready),
    .req(req), .req_rs(req_rs), .req_byte(req_byte), .req_last(req_last),
    .gnt(gnt), .ack(ack), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [7:0] b,
                         input logic rs, input logic last);
    req_byte[8*i +: 8] = b;
    req_rs[i]   = rs;
    req_last[i] = last;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // Returns at the first sample with ack set, or after a bounded budget.
  task automatic wait_ack(input string tag, input logic [N-1:0] exp,
                          output int unsigned cyc);
    logic [N-1:0] who;
    who = '0;
    cyc = 0;
    for (int unsigned i = 1; i <= 200; i++) begin
      step(1);
      if (ack != '0) begin
        who = ack;
        cyc = i;
        break;
      end
    end
    check({tag, "_ack"}, 32'(who), 32'(exp));
  endtask

  // Walks one unlocked byte transfer from the sample just after the grant edge.
  task automatic xfer_check(input string tag, input logic [7:0] b,
                            input logic rs, input int unsigned waitc);
    int unsigned en_cnt;
    en_cnt = 0;
    for (int unsigned off = 1; off <= 32 + waitc; off++) begin
      step(1);
      if (lcd_en) en_cnt++;
      if (off == 1)  check({tag, "_ack_pulse"}, 32'(ack), 0);
      if (off == 2)  check({tag, "_en_rise_hi"}, 32'(lcd_en), 1);
      if (off == 2)  check({tag, "_data_hi"}, 32'(lcd_data), 32'(b[7:4]));
      if (off == 14) check({tag, "_en_fall_hi"}, 32'(lcd_en), 0);
      if (off == 14) check({tag, "_hold_hi"}, 32'(lcd_data), 32'(b[7:4]));
      if (off == 16) check({tag, "_data_lo"}, 32'(lcd_data), 32'(b[3:0]));
      if (off == 16) check({tag, "_rs_lo"}, 32'(lcd_rs), 32'(rs));
      if (off == 18) check({tag, "_en_rise_lo"}, 32'(lcd_en), 1);
      if (off == 30) check({tag, "_en_fall_lo"}, 32'(lcd_en), 0);
      if (off == 30) check({tag, "_hold_lo"}, 32'(lcd_data), 32'(b[3:0]));
      if (off == 32) check({tag, "_wait_data"}, 32'(lcd_data), 0);
      if (off == 31 + waitc) check({tag, "_wait_busy"}, 32'(busy), 1);
      if (off == 32 + waitc) check({tag, "_idle_busy"}, 32'(busy), 0);
      if (off == 32 + waitc) check({tag, "_idle_gnt"}, 32'(gnt), 0);
    end
    check({tag, "_en_cycles"}, en_cnt, 24);
  endtask

  int unsigned cyc;
  logic [N-1:0] rr_exp [4];

  initial begin
    step(2);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_en", 32'(lcd_en), 0);
    check("rst_rs", 32'(lcd_rs), 0);
    check("rst_rw", 32'(lcd_rw), 0);
    check("rst_data", 32'(lcd_data), 0);
    reset = 1'b1;
    lcd_ready = 1'b1;
    step(1);

    // Single data byte 'A'.
    set_req(0, 8'h41, 1'b1, 1'b1);
    req[0] = 1'b1;
    wait_ack("t1", 3'b001, cyc);
    req[0] = 1'b0;
    check("t1_latency", cyc, 1);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_data0", 32'(lcd_data), 4);
    check("t1_rs0", 32'(lcd_rs), 1);
    check("t1_en0", 32'(lcd_en), 0);
    xfer_check("t1", 8'h41, 1'b1, WAITC);

    // Asynchronous reset in the middle of the high-nibble pulse.
    req[0] = 1'b1;
    wait_ack("rstmid", 3'b001, cyc);
    req[0] = 1'b0;
    step(5);
    check("rstmid_en_pre", 32'(lcd_en), 1);
    reset = 1'b0;
    #1;
    check("rstmid_en", 32'(lcd_en), 0);
    check("rstmid_gnt", 32'(gnt), 0);
    check("rstmid_busy", 32'(busy), 0);
    step(1);
    reset = 1'b1;
    step(5);
    check("rstmid_idle_busy", 32'(busy), 0);
    check("rstmid_idle_gnt", 32'(gnt), 0);
    check("rstmid_idle_data", 32'(lcd_data), 0);

    // Clear-display command uses the long wait.
    set_req(0, 8'h01, 1'b0, 1'b1);
    req[0] = 1'b1;
    wait_ack("clr", 3'b001, cyc);
    req[0] = 1'b0;
    check("clr_data0", 32'(lcd_data), 0);
    check("clr_rs0", 32'(lcd_rs), 0);
    xfer_check("clr", 8'h01, 1'b0, CLRC);

    // Round-robin among three held requesters.
    do_reset();
    set_req(0, 8'h10, 1'b1, 1'b1);
    set_req(1, 8'h11, 1'b1, 1'b1);
    set_req(2, 8'h12, 1'b1, 1'b1);
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr", rr_exp[k], cyc);
      step(1);
      check("rr_ack_pulse", 32'(ack), 0);
    end
    req = '0;
    step(60);

    // Locked three-byte message from requester 1 while 0 waits.
    do_reset();
    set_req(1, 8'hA1, 1'b1, 1'b0);
    req = 3'b010;
    wait_ack("lock1", 3'b010, cyc);
    set_req(1, 8'hA2, 1'b1, 1'b0);
    set_req(0, 8'h55, 1'b1, 1'b1);
    req = 3'b011;
    wait_ack("lock2", 3'b010, cyc);
    check("lock_b2b_gap", cyc, 53);
    check("lock2_data", 32'(lcd_data), 32'hA);
    check("lock2_gnt", 32'(gnt), 32'h2);
    set_req(1, 8'hA3, 1'b1, 1'b1);
    wait_ack("lock3", 3'b010, cyc);
    req[1] = 1'b0;
    set_req(2, 8'h77, 1'b1, 1'b1);
    req[2] = 1'b1;
    wait_ack("lock_next", 3'b100, cyc);
    req = '0;
    step(60);

    // Owner abandons a message; lock must release at the end of WAIT.
    do_reset();
    set_req(0, 8'h30, 1'b1, 1'b0);
    req = 3'b001;
    wait_ack("ab1", 3'b001, cyc);
    req[0] = 1'b0;
    set_req(1, 8'h31, 1'b1, 1'b1);
    req[1] = 1'b1;
    wait_ack("ab2", 3'b010, cyc);
    req = '0;
    step(60);

    // No arbitration while the LCD is not ready.
    lcd_ready = 1'b0;
    set_req(2, 8'h44, 1'b1, 1'b1);
    req = 3'b100;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("nrdy_ack", 32'(ack), 0);
      check("nrdy_busy", 32'(busy), 0);
    end
    lcd_ready = 1'b1;
    wait_ack("rdy_resume", 3'b100, cyc);
    check("rdy_latency", cyc, 1);
    req = '0;
    step(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
